// File: rtl/method_call_arbiter_pkg.sv
// Shared definitions for the method-call arbiter: FSM state encoding and
// default parameter values used by the interface, picker and top.
package method_arb_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ARG_W      = 32;
  localparam int DEF_RET_W      = 32;
  localparam int DEF_WAIT_LIMIT = 8;
  localparam int CALL_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_RUN       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/method_call_arbiter_if.sv
// Caller-side and target-side signals of the arbiter; master is the arbiter,
// slave is the environment (callers plus the shared target method).
interface method_call_arbiter_if
  import method_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ARG_W = DEF_ARG_W,
  parameter int RET_W = DEF_RET_W
) ();

  logic [N_REQ-1:0]         caller_req;
  logic [N_REQ-1:0]         caller_busy;
  logic [N_REQ*ARG_W-1:0]   caller_arg;
  logic [RET_W-1:0]         caller_return;
  logic                     target_req;
  logic [ARG_W-1:0]         target_arg;
  logic                     target_busy;
  logic [RET_W-1:0]         target_return;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic [CALL_CNT_W-1:0]    call_count;
  logic                     timeout_err;

  modport master (
    input  caller_req, caller_arg, target_busy, target_return,
    output caller_busy, caller_return, target_req, target_arg,
           grant_id, call_count, timeout_err
  );

  modport slave (
    output caller_req, caller_arg, target_busy, target_return,
    input  caller_busy, caller_return, target_req, target_arg,
           grant_id, call_count, timeout_err
  );

endinterface

// File: rtl/method_call_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first pending index strictly after the
// pointer, wrapping, so a lone pending caller always wins.
module rr_priority_picker
  import method_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] pointer,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan N_REQ slots starting one past the pointer and keep the first hit.
  always_comb begin : pick
    logic [IDX_W-1:0] slot_idx;
    logic             hit;
    valid    = 1'b0;
    index    = '0;
    slot_idx = '0;
    hit      = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      slot_idx = IDX_W'((int'(pointer) + k) % N_REQ);
      hit      = pending[slot_idx] & ~valid;
      index    = hit ? slot_idx : index;
      valid    = valid | hit;
    end
  end

endmodule

// File: rtl/method_call_arbiter.sv
// Arbitrates one-shot method calls from N_REQ callers onto a single target,
// round-robin, with a bounded wait for the target to acknowledge via busy.
module method_call_arbiter
  import method_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ARG_W      = DEF_ARG_W,
  parameter int RET_W      = DEF_RET_W,
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input logic                   clk,
  input logic                   reset,
  method_call_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WC_W  = $clog2(WAIT_LIMIT + 1);

  arb_state_e            state_r;
  logic [N_REQ-1:0]      pending_r;
  logic [N_REQ-1:0]      busy_r;
  logic [N_REQ-1:0]      accept_s;
  logic [ARG_W-1:0]      arg_r [N_REQ];
  logic                  target_req_r;
  logic [ARG_W-1:0]      target_arg_r;
  logic [RET_W-1:0]      caller_return_r;
  logic [IDX_W-1:0]      grant_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_valid_s;
  logic [CALL_CNT_W-1:0] call_count_r;
  logic                  timeout_r;
  logic [WC_W-1:0]       wait_cnt_r;

  // Requests from a caller already busy are dropped, not queued.
  assign accept_s = bus.caller_req & ~busy_r;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .pending (pending_r),
    .pointer (ptr_r),
    .valid   (pick_valid_s),
    .index   (pick_idx_s)
  );

  // Per-caller argument capture on request acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arg_r <= '{default: '0};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept_s[i]) begin
          arg_r[i] <= bus.caller_arg[i*ARG_W +: ARG_W];
        end
      end
    end
  end

  // Call FSM with pending/busy bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      pending_r       <= '0;
      busy_r          <= '0;
      target_req_r    <= 1'b0;
      target_arg_r    <= '0;
      caller_return_r <= '0;
      grant_r         <= '0;
      ptr_r           <= IDX_W'(N_REQ - 1);
      call_count_r    <= '0;
      timeout_r       <= 1'b0;
      wait_cnt_r      <= '0;
    end else begin
      pending_r <= pending_r | accept_s;
      busy_r    <= busy_r | accept_s;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r      <= pick_idx_s;
            ptr_r        <= pick_idx_s;
            target_arg_r <= arg_r[pick_idx_s];
            target_req_r <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          target_req_r       <= 1'b0;
          pending_r[grant_r] <= 1'b0;
          wait_cnt_r         <= '0;
          state_r            <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.target_busy) begin
            state_r <= ST_RUN;
          end else if (wait_cnt_r == WC_W'(WAIT_LIMIT - 1)) begin
            // Target never acknowledged: release the caller, keep last return.
            timeout_r       <= 1'b1;
            busy_r[grant_r] <= 1'b0;
            call_count_r    <= call_count_r + CALL_CNT_W'(1);
            state_r         <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.target_busy) begin
            state_r <= ST_RUN;
          end else begin
            caller_return_r <= bus.target_return;
            busy_r[grant_r] <= 1'b0;
            call_count_r    <= call_count_r + CALL_CNT_W'(1);
            state_r         <= ST_IDLE;
          end
        end
        default: begin
          target_req_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.caller_busy   = busy_r;
  assign bus.caller_return = caller_return_r;
  assign bus.target_req    = target_req_r;
  assign bus.target_arg    = target_arg_r;
  assign bus.grant_id      = grant_r;
  assign bus.call_count    = call_count_r;
  assign bus.timeout_err   = timeout_r;

endmodule

// File: tb/tb_method_call_arbiter.sv
// Directed scoreboard bench: expected calls are queued as stimulus is driven
// and retired against the target_req pulse and the caller's busy fall.
module tb_method_call_arbiter;
  import method_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int RW = 32;

  typedef struct {
    int          id;
    logic [31:0] arg;
    logic [31:0] ret;
    bit          to;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  method_call_arbiter_if #(.N_REQ(N), .ARG_W(AW), .RET_W(RW)) bus ();

  method_call_arbiter #(.N_REQ(N), .ARG_W(AW), .RET_W(RW), .WAIT_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [15:0] exp_count;
  logic [31:0] last_ret;
  bit          exp_to;
  logic [3:0]  exp_busy;
  int          tgt_dur = 4;
  bit          tgt_silent = 1'b0;
  int          t_cnt;
  int          pulses = 0;

  // Target method model: busy for tgt_dur cycles, returns arg ^ 0xFF.
  always @(posedge clk) begin
    if (reset == 1'b0) begin
      bus.target_busy   <= 1'b0;
      bus.target_return <= '0;
      t_cnt             <= 0;
    end else if (t_cnt > 1) begin
      t_cnt <= t_cnt - 1;
    end else if (t_cnt == 1) begin
      t_cnt           <= 0;
      bus.target_busy <= 1'b0;
    end else if (bus.target_req === 1'b1 && !tgt_silent) begin
      bus.target_busy   <= 1'b1;
      bus.target_return <= bus.target_arg ^ 32'h0000_00FF;
      t_cnt             <= tgt_dur;
    end else begin
      t_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (bus.target_req === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] arg, input bit to);
    exp_t e;
    e.id  = id;
    e.arg = arg;
    e.ret = arg ^ 32'h0000_00FF;
    e.to  = to;
    return e;
  endfunction

  function automatic logic [127:0] argv(input int id, input logic [31:0] a);
    logic [127:0] v;
    v = '0;
    v[id*32 +: 32] = a;
    return v;
  endfunction

  task automatic set_req(input logic [3:0] mask, input logic [127:0] args);
    bus.caller_arg = args;
    bus.caller_req = mask;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [127:0] args);
    set_req(mask, args);
    tick();
    bus.caller_req = '0;
  endtask

  task automatic reset_model();
    sb.delete();
    exp_count = '0;
    last_ret  = '0;
    exp_to    = 1'b0;
    exp_busy  = '0;
  endtask

  // Retire the oldest expected call: check its issue, then its completion.
  task automatic service(output int lat, output int dc);
    exp_t e;
    bit   seen;
    bit   done;
    e    = sb.pop_front();
    seen = 1'b0;
    done = 1'b0;
    lat  = 0;
    dc   = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      tick();
      bus.caller_req = '0;
      if (bus.target_req === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("issue_seen", 64'(seen), 64'd1);
    chk("grant_id", 64'(bus.grant_id), 64'(e.id));
    chk("target_arg", 64'(bus.target_arg), 64'(e.arg));
    tick();
    dc = 1;
    chk("req_pulse_width", 64'(bus.target_req), 64'd0);
    for (int k = 0; k < 60 && !done; k++) begin
      if (bus.caller_busy[e.id] === 1'b0) begin
        done = 1'b1;
      end else begin
        tick();
        dc++;
      end
    end
    chk("complete_seen", 64'(done), 64'd1);
    if (e.to) exp_to = 1'b1;
    else last_ret = e.ret;
    exp_count++;
    exp_busy[e.id] = 1'b0;
    chk("caller_return", 64'(bus.caller_return), 64'(last_ret));
    chk("call_count", 64'(bus.call_count), 64'(exp_count));
    chk("timeout_err", 64'(bus.timeout_err), 64'(exp_to));
    chk("caller_busy", 64'(bus.caller_busy), 64'(exp_busy));
  endtask

  initial begin
    int lat;
    int dc;
    int p0;
    reset          = 1'b0;
    bus.caller_req = '0;
    bus.caller_arg = '0;
    reset_model();
    repeat (3) tick();
    chk("rst_busy", 64'(bus.caller_busy), 64'd0);
    chk("rst_treq", 64'(bus.target_req), 64'd0);
    chk("rst_targ", 64'(bus.target_arg), 64'd0);
    chk("rst_ret", 64'(bus.caller_return), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_count", 64'(bus.call_count), 64'd0);
    chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
    reset = 1'b1;
    tick();

    // All four callers at once: caller 0 first after reset.
    drive(4'hF, argv(0, 32'h10) | argv(1, 32'h11) | argv(2, 32'h12) | argv(3, 32'h13));
    exp_busy = 4'hF;
    chk("busy_set", 64'(bus.caller_busy), 64'hF);
    for (int i = 0; i < 4; i++) sb.push_back(mk(i, 32'h10 + 32'(i), 1'b0));
    for (int i = 0; i < 4; i++) service(lat, dc);

    // Single call, caller 1, arg 0x55 -> return 0xAA.
    p0 = pulses;
    drive(4'b0010, argv(1, 32'h55));
    exp_busy[1] = 1'b1;
    sb.push_back(mk(1, 32'h55, 1'b0));
    service(lat, dc);
    chk("arb_latency", 64'(lat), 64'd1);
    chk("single_pulse", 64'(pulses - p0), 64'd1);

    // Caller 2 re-requests right after completing while 3 still pending.
    set_req(4'b1100, argv(2, 32'h22) | argv(3, 32'h33));
    exp_busy = exp_busy | 4'b1100;
    sb.push_back(mk(2, 32'h22, 1'b0));
    sb.push_back(mk(3, 32'h33, 1'b0));
    service(lat, dc);
    set_req(4'b0100, argv(2, 32'h24));
    exp_busy[2] = 1'b1;
    sb.push_back(mk(2, 32'h24, 1'b0));
    service(lat, dc);
    service(lat, dc);

    // Request while busy on caller 0 is ignored and does not clobber the arg.
    p0 = pulses;
    drive(4'b0001, argv(0, 32'h77));
    exp_busy[0] = 1'b1;
    sb.push_back(mk(0, 32'h77, 1'b0));
    set_req(4'b0001, argv(0, 32'h99));
    service(lat, dc);
    repeat (6) tick();
    chk("ignored_pulses", 64'(pulses - p0), 64'd1);
    chk("ignored_busy", 64'(bus.caller_busy), 64'd0);

    // Target never raises busy.
    tgt_silent = 1'b1;
    set_req(4'b1000, argv(3, 32'h42));
    exp_busy[3] = 1'b1;
    sb.push_back(mk(3, 32'h42, 1'b1));
    service(lat, dc);
    chk("timeout_latency", 64'(dc), 64'd9);
    tgt_silent = 1'b0;

    // timeout_err stays set across a normal call.
    set_req(4'b0010, argv(1, 32'h66));
    exp_busy[1] = 1'b1;
    sb.push_back(mk(1, 32'h66, 1'b0));
    service(lat, dc);

    // Reset in the middle of a running call.
    tgt_dur = 20;
    drive(4'b0010, argv(1, 32'h31));
    repeat (4) tick();
    chk("pre_rst_busy", 64'(bus.caller_busy), 64'h2);
    chk("pre_rst_tbusy", 64'(bus.target_busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.caller_busy), 64'd0);
    chk("arst_treq", 64'(bus.target_req), 64'd0);
    chk("arst_targ", 64'(bus.target_arg), 64'd0);
    chk("arst_ret", 64'(bus.caller_return), 64'd0);
    chk("arst_grant", 64'(bus.grant_id), 64'd0);
    chk("arst_count", 64'(bus.call_count), 64'd0);
    chk("arst_tmo", 64'(bus.timeout_err), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    reset_model();
    tgt_dur = 4;
    p0 = pulses;
    repeat (10) tick();
    chk("post_rst_pulses", 64'(pulses - p0), 64'd0);
    chk("post_rst_count", 64'(bus.call_count), 64'd0);

    // Arbiter still operational after the abandoned call.
    set_req(4'b0100, argv(2, 32'hC3));
    exp_busy[2] = 1'b1;
    sb.push_back(mk(2, 32'hC3, 1'b0));
    service(lat, dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
